// File: rtl/riscv_pkg.sv
// Shared decode definitions for the RV64 pipeline slice.
//
// Contents:
//   - opcode constants for the instruction classes the ID/EX stage cares about
//   - ALUOp encodings produced by the decode control unit
//   - ctrl_t: the nine decode control bits bundled as one packed word
//   - CTRL_BUBBLE: the all-zero control word used when a bubble is injected
//   - uses_rs1 / uses_rs2: which register sources an opcode actually reads
package riscv_pkg;

    localparam logic [6:0] ALU_R     = 7'b0110011;
    localparam logic [6:0] ALU_I     = 7'b0010011;
    localparam logic [6:0] BRANCH_EQ = 7'b1100011;
    localparam logic [6:0] JUMP      = 7'b1101111;
    localparam logic [6:0] LOAD      = 7'b0000011;
    localparam logic [6:0] STORE     = 7'b0100011;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_SUB    = 2'b01;
    localparam logic [1:0] ALUOP_R_TYPE = 2'b10;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       branch;
        logic       mem_read;
        logic       mem_2_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic       jump;
    } ctrl_t;

    // A bubble must look like a NOP to every later stage: nothing written,
    // nothing loaded or stored, no control transfer.
    localparam ctrl_t CTRL_BUBBLE = '0;

    // Jumps read no register here, and unknown opcodes are treated the same
    // way so that garbage in ID can never stall the pipe.
    function automatic logic uses_rs1(input logic [6:0] opcode);
        return (opcode == ALU_R) || (opcode == ALU_I) || (opcode == LOAD) ||
               (opcode == STORE) || (opcode == BRANCH_EQ);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opcode);
        return (opcode == ALU_R) || (opcode == STORE) || (opcode == BRANCH_EQ);
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector.
//
// Raises hz when the instruction now in EX is a real load whose destination
// (other than x0) is a register the instruction in ID is about to read.
//
// Ports:
//   id_opcode   in  7       opcode of the instruction in ID
//   id_rs1      in  REG_AW  first source index in ID
//   id_rs2      in  REG_AW  second source index in ID
//   ex_rd       in  REG_AW  destination index of the instruction in EX
//   ex_mem_read in  1       instruction in EX is a load
//   ex_valid    in  1       EX slot holds a real instruction
//   hz          out 1       load-use hazard present (combinational)
module load_use_detect
    import riscv_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [6:0]        id_opcode,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mem_read,
    input  logic              ex_valid,
    output logic              hz
);

    logic rs1_match;
    logic rs2_match;
    logic load_in_ex;

    // x0 is hardwired to zero, so a load targeting it produces nothing that
    // a consumer could be waiting on.
    assign load_in_ex = ex_valid && ex_mem_read && (ex_rd != '0);
    assign rs1_match  = uses_rs1(id_opcode) && (ex_rd == id_rs1);
    assign rs2_match  = uses_rs2(id_opcode) && (ex_rd == id_rs2);
    assign hz         = load_in_ex && (rs1_match || rs2_match);

endmodule

// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use stall and bubble injection.
//
// Captures the decode control word, operands and register indices and
// presents them to EX one cycle later. A load-use hazard freezes PC/IF_ID
// through stall and drops a bubble into EX; a flush from branch/jump
// resolution also drops a bubble but is not counted.
//
// Ports:
//   clk, arst_n            clock; synchronous active-low reset
//   pipe_en                0 holds every register (memory wait)
//   flush_id_ex            discard the instruction in ID
//   id_opcode, id_func     opcode and {instr[30], instr[14:12]}
//   id_alu_op, id_branch, id_mem_read, id_mem_2_reg, id_mem_write,
//   id_alu_src, id_reg_write, id_jump   decode control
//   id_rs1, id_rs2, id_rd  register indices
//   id_rdata1, id_rdata2, id_imm, id_pc  operands
//   ex_*                   registered copies of the above for EX
//   ex_valid               EX slot holds a real instruction
//   stall                  combinational; hold PC and IF/ID this cycle
//   bubble_cnt             saturating count of hazard bubbles
module id_ex_hazard_reg
    import riscv_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              pipe_en,
    input  logic              flush_id_ex,
    input  logic [6:0]        id_opcode,
    input  logic [1:0]        id_alu_op,
    input  logic              id_branch,
    input  logic              id_mem_read,
    input  logic              id_mem_2_reg,
    input  logic              id_mem_write,
    input  logic              id_alu_src,
    input  logic              id_reg_write,
    input  logic              id_jump,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [DATA_W-1:0] id_rdata1,
    input  logic [DATA_W-1:0] id_rdata2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [3:0]        id_func,
    output logic [1:0]        ex_alu_op,
    output logic              ex_branch,
    output logic              ex_mem_read,
    output logic              ex_mem_2_reg,
    output logic              ex_mem_write,
    output logic              ex_alu_src,
    output logic              ex_reg_write,
    output logic              ex_jump,
    output logic [REG_AW-1:0] ex_rs1,
    output logic [REG_AW-1:0] ex_rs2,
    output logic [REG_AW-1:0] ex_rd,
    output logic [DATA_W-1:0] ex_rdata1,
    output logic [DATA_W-1:0] ex_rdata2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [DATA_W-1:0] ex_pc,
    output logic [3:0]        ex_func,
    output logic              ex_valid,
    output logic              stall,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    ctrl_t             id_ctrl;
    ctrl_t             ex_ctrl;
    logic [REG_AW-1:0] rs1_q, rs2_q, rd_q;
    logic [DATA_W-1:0] rdata1_q, rdata2_q, imm_q, pc_q;
    logic [3:0]        func_q;
    logic              valid_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              hz;

    assign id_ctrl = '{
        alu_op:    id_alu_op,
        branch:    id_branch,
        mem_read:  id_mem_read,
        mem_2_reg: id_mem_2_reg,
        mem_write: id_mem_write,
        alu_src:   id_alu_src,
        reg_write: id_reg_write,
        jump:      id_jump
    };

    load_use_detect #(
        .REG_AW(REG_AW)
    ) u_detect (
        .id_opcode  (id_opcode),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .ex_rd      (rd_q),
        .ex_mem_read(ex_ctrl.mem_read),
        .ex_valid   (valid_q),
        .hz         (hz)
    );

    // A flush discards the dependent instruction anyway, so there is nothing
    // to wait for; and while the pipe is frozen nothing advances, so there is
    // nothing to hold back either.
    assign stall = hz && !flush_id_ex && pipe_en;

    // Pipeline register. Priority: reset, global hold, flush, hazard bubble,
    // normal capture. Bubbles zero the data fields too so EX never sees stale
    // operands attached to an invalid slot.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            ex_ctrl  <= CTRL_BUBBLE;
            rs1_q    <= '0;
            rs2_q    <= '0;
            rd_q     <= '0;
            rdata1_q <= '0;
            rdata2_q <= '0;
            imm_q    <= '0;
            pc_q     <= '0;
            func_q   <= '0;
            valid_q  <= 1'b0;
            cnt_q    <= '0;
        end else if (pipe_en) begin
            if (flush_id_ex || hz) begin
                ex_ctrl  <= CTRL_BUBBLE;
                rs1_q    <= '0;
                rs2_q    <= '0;
                rd_q     <= '0;
                rdata1_q <= '0;
                rdata2_q <= '0;
                imm_q    <= '0;
                pc_q     <= '0;
                func_q   <= '0;
                valid_q  <= 1'b0;
                // Only hazard bubbles are a performance cost worth counting;
                // the counter sticks at all-ones rather than wrapping.
                if (!flush_id_ex && (cnt_q != CNT_MAX)) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end else begin
                ex_ctrl  <= id_ctrl;
                rs1_q    <= id_rs1;
                rs2_q    <= id_rs2;
                rd_q     <= id_rd;
                rdata1_q <= id_rdata1;
                rdata2_q <= id_rdata2;
                imm_q    <= id_imm;
                pc_q     <= id_pc;
                func_q   <= id_func;
                valid_q  <= 1'b1;
            end
        end
    end

    assign ex_alu_op    = ex_ctrl.alu_op;
    assign ex_branch    = ex_ctrl.branch;
    assign ex_mem_read  = ex_ctrl.mem_read;
    assign ex_mem_2_reg = ex_ctrl.mem_2_reg;
    assign ex_mem_write = ex_ctrl.mem_write;
    assign ex_alu_src   = ex_ctrl.alu_src;
    assign ex_reg_write = ex_ctrl.reg_write;
    assign ex_jump      = ex_ctrl.jump;
    assign ex_rs1       = rs1_q;
    assign ex_rs2       = rs2_q;
    assign ex_rd        = rd_q;
    assign ex_rdata1    = rdata1_q;
    assign ex_rdata2    = rdata2_q;
    assign ex_imm       = imm_q;
    assign ex_pc        = pc_q;
    assign ex_func      = func_q;
    assign ex_valid     = valid_q;
    assign bubble_cnt   = cnt_q;

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Self-checking bench for id_ex_hazard_reg.
//
// A small instruction-level model tracks what should sit in the EX slot,
// whether it is real, and how many hazard bubbles have been paid. The
// counter width is reduced so saturation is reachable in a short run.
module tb_id_ex_hazard_reg;
    import riscv_pkg::*;

    localparam int DATA_W = 64;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [1:0]        alu_op;
        logic              branch;
        logic              mem_read;
        logic              mem_2_reg;
        logic              mem_write;
        logic              alu_src;
        logic              reg_write;
        logic              jump;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] rdata1;
        logic [DATA_W-1:0] rdata2;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] pc;
        logic [3:0]        func;
    } slot_t;

    logic             clk = 1'b0;
    logic             arst_n;
    logic             pipe_en;
    logic             flush_id_ex;
    logic [6:0]       opcode;
    slot_t            id_in;
    slot_t            obs;
    logic [1:0]       ex_alu_op;
    logic             ex_branch, ex_mem_read, ex_mem_2_reg, ex_mem_write;
    logic             ex_alu_src, ex_reg_write, ex_jump;
    logic [REG_AW-1:0] ex_rs1, ex_rs2, ex_rd;
    logic [DATA_W-1:0] ex_rdata1, ex_rdata2, ex_imm, ex_pc;
    logic [3:0]       ex_func;
    logic             ex_valid;
    logic             stall;
    logic [CNT_W-1:0] bubble_cnt;

    // Reference model state
    slot_t m_slot;
    bit    m_valid;
    int    m_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    id_ex_hazard_reg #(
        .DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .arst_n(arst_n), .pipe_en(pipe_en), .flush_id_ex(flush_id_ex),
        .id_opcode(opcode), .id_alu_op(id_in.alu_op), .id_branch(id_in.branch),
        .id_mem_read(id_in.mem_read), .id_mem_2_reg(id_in.mem_2_reg),
        .id_mem_write(id_in.mem_write), .id_alu_src(id_in.alu_src),
        .id_reg_write(id_in.reg_write), .id_jump(id_in.jump),
        .id_rs1(id_in.rs1), .id_rs2(id_in.rs2), .id_rd(id_in.rd),
        .id_rdata1(id_in.rdata1), .id_rdata2(id_in.rdata2),
        .id_imm(id_in.imm), .id_pc(id_in.pc), .id_func(id_in.func),
        .ex_alu_op(ex_alu_op), .ex_branch(ex_branch), .ex_mem_read(ex_mem_read),
        .ex_mem_2_reg(ex_mem_2_reg), .ex_mem_write(ex_mem_write),
        .ex_alu_src(ex_alu_src), .ex_reg_write(ex_reg_write), .ex_jump(ex_jump),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm), .ex_pc(ex_pc),
        .ex_func(ex_func), .ex_valid(ex_valid), .stall(stall), .bubble_cnt(bubble_cnt)
    );

    assign obs = {ex_alu_op, ex_branch, ex_mem_read, ex_mem_2_reg, ex_mem_write,
                  ex_alu_src, ex_reg_write, ex_jump, ex_rs1, ex_rs2, ex_rd,
                  ex_rdata1, ex_rdata2, ex_imm, ex_pc, ex_func};

    // Which source registers an instruction class reads
    function automatic bit reads_src(input logic [6:0] op, input int which);
        if (which == 1) return op inside {ALU_R, ALU_I, LOAD, STORE, BRANCH_EQ};
        return op inside {ALU_R, STORE, BRANCH_EQ};
    endfunction

    // A load in EX whose nonzero result is read by the instruction in ID
    function automatic bit model_hazard();
        if (!(m_valid && m_slot.mem_read && m_slot.rd != 0)) return 0;
        return (reads_src(opcode, 1) && m_slot.rd == id_in.rs1) ||
               (reads_src(opcode, 2) && m_slot.rd == id_in.rs2);
    endfunction

    function automatic bit model_stall();
        return model_hazard() && !flush_id_ex && pipe_en;
    endfunction

    function automatic slot_t rand_slot();
        slot_t s;
        s.alu_op    = 2'($urandom);
        s.branch    = 1'($urandom);
        s.mem_read  = 1'($urandom);
        s.mem_2_reg = 1'($urandom);
        s.mem_write = 1'($urandom);
        s.alu_src   = 1'($urandom);
        s.reg_write = 1'($urandom);
        s.jump      = 1'($urandom);
        s.rs1       = REG_AW'($urandom);
        s.rs2       = REG_AW'($urandom);
        s.rd        = REG_AW'($urandom);
        s.rdata1    = {$urandom, $urandom};
        s.rdata2    = {$urandom, $urandom};
        s.imm       = {$urandom, $urandom};
        s.pc        = {$urandom, $urandom};
        s.func      = 4'($urandom);
        return s;
    endfunction

    task automatic set_load(input logic [REG_AW-1:0] rd);
        opcode = LOAD;
        id_in = rand_slot();
        id_in.rd = rd;
        id_in.mem_read = 1'b1;
        id_in.reg_write = 1'b1;
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [REG_AW-1:0] rs1,
                             input logic [REG_AW-1:0] rs2);
        opcode = op;
        id_in = rand_slot();
        id_in.rs1 = rs1;
        id_in.rs2 = rs2;
        id_in.mem_read = 1'b0;
    endtask

    // One rising edge; the model advances using the inputs seen at that edge
    task automatic tick();
        bit hz;
        @(posedge clk);
        hz = model_hazard();
        if (!arst_n) begin
            m_slot = '0; m_valid = 0; m_cnt = 0;
        end else if (pipe_en) begin
            if (flush_id_ex) begin
                m_slot = '0; m_valid = 0;
            end else if (hz) begin
                m_slot = '0; m_valid = 0;
                if (m_cnt < CNT_MAX) m_cnt++;
            end else begin
                m_slot = id_in; m_valid = 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        arst_n = 0; pipe_en = 1; flush_id_ex = 0;
        opcode = 7'($urandom); id_in = rand_slot();
        tick();
        opcode = 7'($urandom); id_in = rand_slot();
        tick();
        #1;
        checks++;
        if (obs !== '0) begin
            failures++; $display("[TB] FAIL reset_ex_fields got=%h want=0", obs);
        end
        checks++;
        if (ex_valid !== 1'b0 || stall !== 1'b0 || bubble_cnt !== '0) begin
            failures++;
            $display("[TB] FAIL reset_flags got valid=%b stall=%b cnt=%0d want 0/0/0",
                     ex_valid, stall, bubble_cnt);
        end
        arst_n = 1;
    endtask

    task automatic test_load_use();
        set_load(5);
        tick();
        set_instr(ALU_R, 5, 6);
        #1;
        checks++;
        if (stall !== 1'b1) begin
            failures++; $display("[TB] FAIL load_use_stall got=%b want=1", stall);
        end
        tick();
        checks++;
        if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || bubble_cnt !== 1) begin
            failures++;
            $display("[TB] FAIL load_use_bubble got valid=%b rw=%b cnt=%0d want 0/0/1",
                     ex_valid, ex_reg_write, bubble_cnt);
        end
        checks++;
        if (stall !== 1'b0) begin
            failures++; $display("[TB] FAIL load_use_release got=%b want=0", stall);
        end
        tick();
        checks++;
        if (obs !== m_slot || ex_valid !== 1'b1 || ex_rs1 !== 5) begin
            failures++;
            $display("[TB] FAIL load_use_advance got=%h/%b want=%h/1", obs, ex_valid, m_slot);
        end
    endtask

    task automatic test_rd_zero();
        set_load(0);
        tick();
        set_instr(ALU_R, 0, 0);
        #1;
        checks++;
        if (stall !== 1'b0) begin
            failures++; $display("[TB] FAIL rd_zero_stall got=%b want=0", stall);
        end
        tick();
        checks++;
        if (obs !== m_slot || ex_valid !== 1'b1) begin
            failures++; $display("[TB] FAIL rd_zero_advance got=%h want=%h", obs, m_slot);
        end
    endtask

    task automatic test_jump();
        set_load(7);
        tick();
        set_instr(JUMP, 7, 7);
        #1;
        checks++;
        if (stall !== 1'b0) begin
            failures++; $display("[TB] FAIL jump_stall got=%b want=0", stall);
        end
        tick();
    endtask

    task automatic test_store_rs2();
        set_load(7);
        tick();
        set_instr(STORE, 1, 7);
        #1;
        checks++;
        if (stall !== 1'b1) begin
            failures++; $display("[TB] FAIL store_rs2_stall got=%b want=1", stall);
        end
        tick();
        checks++;
        if (ex_valid !== 1'b0 || ex_mem_write !== 1'b0 || bubble_cnt !== m_cnt) begin
            failures++;
            $display("[TB] FAIL store_rs2_bubble got valid=%b cnt=%0d want 0/%0d",
                     ex_valid, bubble_cnt, m_cnt);
        end
        tick();
    endtask

    task automatic test_flush();
        int cnt_before;
        set_load(3);
        tick();
        cnt_before = int'(bubble_cnt);
        set_instr(BRANCH_EQ, 3, 9);
        flush_id_ex = 1;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            failures++; $display("[TB] FAIL flush_stall got=%b want=0", stall);
        end
        tick();
        flush_id_ex = 0;
        checks++;
        if (obs !== '0 || ex_valid !== 1'b0 || int'(bubble_cnt) !== cnt_before) begin
            failures++;
            $display("[TB] FAIL flush_bubble got=%h valid=%b cnt=%0d want 0/0/%0d",
                     obs, ex_valid, bubble_cnt, cnt_before);
        end
    endtask

    task automatic test_pipe_hold();
        slot_t held;
        set_load(9);
        tick();
        held = m_slot;
        set_instr(ALU_I, 9, 0);
        pipe_en = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (stall !== 1'b0) begin
                failures++; $display("[TB] FAIL hold_stall cycle=%0d got=%b want=0", i, stall);
            end
            tick();
            checks++;
            if (obs !== held || ex_valid !== 1'b1 || bubble_cnt !== m_cnt) begin
                failures++;
                $display("[TB] FAIL hold_frozen cycle=%0d got=%h cnt=%0d want=%h cnt=%0d",
                         i, obs, bubble_cnt, held, m_cnt);
            end
        end
        pipe_en = 1;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            failures++; $display("[TB] FAIL hold_resume_stall got=%b want=1", stall);
        end
        tick();
        tick();
        checks++;
        if (obs !== m_slot || ex_valid !== 1'b1 || bubble_cnt !== m_cnt) begin
            failures++;
            $display("[TB] FAIL hold_resume_advance got=%h cnt=%0d want=%h cnt=%0d",
                     obs, bubble_cnt, m_slot, m_cnt);
        end
    endtask

    task automatic test_reset_mid_stall();
        set_load(4);
        tick();
        set_instr(ALU_R, 1, 4);
        arst_n = 0;
        tick();
        #1;
        checks++;
        if (stall !== 1'b0 || ex_valid !== 1'b0 || bubble_cnt !== '0) begin
            failures++;
            $display("[TB] FAIL reset_mid_stall got stall=%b valid=%b cnt=%0d want 0/0/0",
                     stall, ex_valid, bubble_cnt);
        end
        arst_n = 1;
    endtask

    task automatic test_random();
        logic [6:0] ops [7] = '{ALU_R, ALU_I, LOAD, STORE, BRANCH_EQ, JUMP, 7'h7F};
        for (int i = 0; i < 300; i++) begin
            opcode = ops[$urandom_range(0, 6)];
            id_in = rand_slot();
            id_in.rs1 = REG_AW'($urandom_range(0, 3));
            id_in.rs2 = REG_AW'($urandom_range(0, 3));
            id_in.rd  = REG_AW'($urandom_range(0, 3));
            id_in.mem_read = (opcode == LOAD) ? 1'b1 : 1'($urandom_range(0, 7) == 0);
            flush_id_ex = ($urandom_range(0, 9) == 0);
            pipe_en = ($urandom_range(0, 7) != 0);
            #1;
            checks++;
            if (stall !== model_stall()) begin
                failures++;
                $display("[TB] FAIL random_stall step=%0d got=%b want=%b", i, stall, model_stall());
            end
            tick();
            checks++;
            if (obs !== m_slot || ex_valid !== m_valid || bubble_cnt !== m_cnt) begin
                failures++;
                $display("[TB] FAIL random_slot step=%0d got=%h/%b/%0d want=%h/%b/%0d",
                         i, obs, ex_valid, bubble_cnt, m_slot, m_valid, m_cnt);
            end
        end
        flush_id_ex = 0;
        pipe_en = 1;
    endtask

    // A load that reads its own destination: alternating capture and bubble
    task automatic test_saturate();
        int hz_seen = 0;
        set_load(5);
        id_in.rs1 = 5;
        for (int i = 0; i < 2 * (CNT_MAX + 4); i++) begin
            if (stall === 1'b1) hz_seen++;
            tick();
        end
        checks++;
        if (bubble_cnt !== CNT_W'(CNT_MAX) || m_cnt != CNT_MAX) begin
            failures++;
            $display("[TB] FAIL saturate_value got=%0d want=%0d", bubble_cnt, CNT_MAX);
        end
        checks++;
        if (hz_seen <= CNT_MAX) begin
            failures++;
            $display("[TB] FAIL saturate_hazards got=%0d want>%0d", hz_seen, CNT_MAX);
        end
        if (ex_valid !== 1'b1) tick();
        #1;
        checks++;
        if (stall !== 1'b1) begin
            failures++; $display("[TB] FAIL saturate_stall got=%b want=1", stall);
        end
        tick();
        checks++;
        if (bubble_cnt !== CNT_W'(CNT_MAX) || ex_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL saturate_hold got=%0d valid=%b want=%0d/0",
                     bubble_cnt, ex_valid, CNT_MAX);
        end
    endtask

    initial begin
        m_slot = '0; m_valid = 0; m_cnt = 0;
        arst_n = 0; pipe_en = 1; flush_id_ex = 0;
        opcode = '0; id_in = '0;
        @(negedge clk);
        test_reset();
        test_load_use();
        test_rd_zero();
        test_jump();
        test_store_rs2();
        test_flush();
        test_pipe_hold();
        test_reset_mid_stall();
        test_random();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
